// File: rtl/md_pkg.sv
// Shared types and op-classification helpers for the E-stage
// multiply/divide unit.
package md_pkg;

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MADD  = 4'd5,
        OP_MADDU = 4'd6,
        OP_MSUB  = 4'd7,
        OP_MSUBU = 4'd8,
        OP_MTHI  = 4'd9,
        OP_MTLO  = 4'd10
    } md_op_e;

    function automatic logic is_mult(md_op_e op);
        return op inside {OP_MULT, OP_MULTU, OP_MADD,
                          OP_MADDU, OP_MSUB, OP_MSUBU};
    endfunction

    function automatic logic is_div(md_op_e op);
        return op inside {OP_DIV, OP_DIVU};
    endfunction

    function automatic logic is_acc(md_op_e op);
        return op inside {OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
    endfunction

    function automatic logic is_sub(md_op_e op);
        return op inside {OP_MSUB, OP_MSUBU};
    endfunction

    function automatic logic is_signed_op(md_op_e op);
        return op inside {OP_MULT, OP_DIV, OP_MADD, OP_MSUB};
    endfunction

endpackage

// File: rtl/md_compute.sv
// Combinational datapath: produces the {hi,lo} value an operation
// will commit, plus the divide-by-zero indication.
import md_pkg::*;

module md_compute #(
    parameter int WIDTH = 32
) (
    input  md_op_e             op,
    input  logic [WIDTH-1:0]   rs_data,
    input  logic [WIDTH-1:0]   rt_data,
    input  logic [WIDTH-1:0]   hi_in,
    input  logic [WIDTH-1:0]   lo_in,
    output logic [WIDTH-1:0]   res_hi,
    output logic [WIDTH-1:0]   res_lo,
    output logic               div_zero
);

    logic                 sgn;
    logic [2*WIDTH-1:0]   a_ext;
    logic [2*WIDTH-1:0]   b_ext;
    logic [2*WIDTH-1:0]   prod;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   res;
    logic                 a_neg;
    logic                 b_neg;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic [WIDTH-1:0]     b_safe;
    logic [WIDTH-1:0]     q_mag;
    logic [WIDTH-1:0]     r_mag;
    logic [WIDTH-1:0]     quot;
    logic [WIDTH-1:0]     rem;
    logic                 dz;

    always_comb begin
        sgn   = is_signed_op(op);
        // Extending to 2*WIDTH makes the truncated product exact for both signednesses
        a_ext = sgn ? {{WIDTH{rs_data[WIDTH-1]}}, rs_data}
                    : {{WIDTH{1'b0}}, rs_data};
        b_ext = sgn ? {{WIDTH{rt_data[WIDTH-1]}}, rt_data}
                    : {{WIDTH{1'b0}}, rt_data};
        prod  = a_ext * b_ext;
        acc   = {hi_in, lo_in};

        a_neg  = sgn & rs_data[WIDTH-1];
        b_neg  = sgn & rt_data[WIDTH-1];
        a_mag  = a_neg ? -rs_data : rs_data;
        b_mag  = b_neg ? -rt_data : rt_data;
        dz     = (rt_data == '0);
        b_safe = dz ? WIDTH'(1) : b_mag;
        q_mag  = a_mag / b_safe;
        r_mag  = a_mag % b_safe;
        quot   = (a_neg ^ b_neg) ? -q_mag : q_mag;
        rem    = a_neg ? -r_mag : r_mag;

        res      = acc;
        div_zero = 1'b0;
        unique case (1'b1)
            is_div(op): begin
                div_zero = dz;
                res      = dz ? acc : {rem, quot};
            end
            is_acc(op): begin
                res = is_sub(op) ? acc - prod : acc + prod;
            end
            is_mult(op) && !is_acc(op): begin
                res = prod;
            end
            default: begin
                res = acc;
            end
        endcase

        res_hi = res[2*WIDTH-1:WIDTH];
        res_lo = res[WIDTH-1:0];
    end

endmodule

// File: rtl/md_unit_param.sv
// Multi-cycle multiply/divide unit owning HI/LO; busy drives the stall
// unit, results commit after a fixed per-operation latency.
import md_pkg::*;

module md_unit_param #(
    parameter int WIDTH    = 32,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int CNT_W    = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  md_op_e             op,
    input  logic [WIDTH-1:0]   rs_data,
    input  logic [WIDTH-1:0]   rt_data,
    output logic               busy,
    output logic               done,
    output logic               div_zero,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] pend_hi_q, pend_hi_d;
    logic [WIDTH-1:0] pend_lo_q, pend_lo_d;

    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;
    logic             res_dz;

    md_compute #(
        .WIDTH (WIDTH)
    ) u_compute (
        .op       (op),
        .rs_data  (rs_data),
        .rt_data  (rt_data),
        .hi_in    (hi_q),
        .lo_in    (lo_q),
        .res_hi   (res_hi),
        .res_lo   (res_lo),
        .div_zero (res_dz)
    );

    always_comb begin
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        dz_d      = 1'b0;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;

        if (busy_q) begin
            if (cnt_q == CNT_W'(1)) begin
                hi_d   = pend_hi_q;
                lo_d   = pend_lo_q;
                cnt_d  = '0;
                busy_d = 1'b0;
                done_d = 1'b1;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end else if (start) begin
            unique case (1'b1)
                is_mult(op): begin
                    pend_hi_d = res_hi;
                    pend_lo_d = res_lo;
                    cnt_d     = CNT_W'(MULT_LAT);
                    busy_d    = 1'b1;
                end
                is_div(op): begin
                    pend_hi_d = res_hi;
                    pend_lo_d = res_lo;
                    cnt_d     = CNT_W'(DIV_LAT);
                    busy_d    = 1'b1;
                    dz_d      = res_dz;
                end
                op == OP_MTHI: hi_d = rs_data;
                op == OP_MTLO: lo_d = rs_data;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dz_q      <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dz_q      <= dz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = dz_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule
